latch_drive_ctrl: RTL and testbench
===================================

Name: latch_drive_ctrl

Overview:
Clocked sequencer that drives the din/enable inputs of the downstream level-sensitive simple_latch.
- On request, captures a data bit, presents it with setup margin, opens enable for a programmable window, then holds data stable after enable falls.
- Guarantees the latch never sees din change while enable is high.

Parameters:
SETUP_CYC, 1, cycles din is stable before enable rises (>=1)
PULSE_CYC, 2, cycles enable is high (>=1)
HOLD_CYC, 1, cycles din is held after enable falls (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
req  input  1  start request; sampled only in IDLE
data_in  input  1  bit to write, captured on accepted req
q_fb  input  1  latch q readback; used only with LATCH_READBACK_EN
din  output  1  registered data to latch din
enable  output  1  registered enable to latch
busy  output  1  high while a write sequence is in progress
done  output  1  one-cycle pulse when a sequence completes
err  output  1  readback mismatch flag (see Optional Feature)

Behaviour:
- All outputs registered. Reset (rst=1 at a clk edge) forces: state=IDLE, din=0, enable=0, busy=0, done=0, err=0, counter=0.
- Reset mid-sequence aborts immediately. Enable drops on that edge, and no done pulse is produced.
- Counter width is $clog2(max(SETUP_CYC,PULSE_CYC,HOLD_CYC)+1), minimum 1. It is cleared on every state change.
- FSM states: IDLE, SETUP, PULSE, HOLD.
- IDLE:
  - If req=1: din<=data_in, busy<=1, go to SETUP.
  - Otherwise stay; din retains its last value.
- SETUP: enable=0. After SETUP_CYC cycles, go to PULSE.
- PULSE: enable=1. After PULSE_CYC cycles, go to HOLD.
- HOLD: enable=0, din unchanged. After HOLD_CYC cycles, go to IDLE with busy<=0 and done<=1 for exactly one cycle.
- Each phase lasts exactly its parameter count of cycles.
  - busy is high for SETUP_CYC+PULSE_CYC+HOLD_CYC consecutive cycles.
  - done rises on the edge where busy falls.
- req while busy: ignored, not queued. data_in changes while busy do not affect din.
- Back-to-back: req=1 in the done cycle (state IDLE) is accepted. busy re-asserts on the next edge, so there is one idle/done cycle between sequences.
- din never changes while enable=1, and enable never rises on the same edge din changes.

Optional Feature:
Macro LATCH_READBACK_EN.
- Defined:
  - On the last HOLD cycle, q_fb is compared with din.
  - err<=1 if they differ, simultaneous with done.
  - err stays set (sticky) until rst or the next accepted req, which clears it.
- Not defined: q_fb is ignored and err is constant 0.

Test Plan:
- Reset: rst=1 for 2 cycles with req=1, data_in=1 -> din=0, enable=0, busy=0, done=0, err=0 throughout.
- Single write, defaults, req=1 and data_in=1 at edge E0 -> din=1 from E0+1; enable=1 for cycles E0+2..E0+3 only; busy=1 for E0+1..E0+4; done=1 only in cycle E0+5.
- Ignored req: req=1 with data_in=0 during cycles E0+2..E0+4 of a write of 1 -> din stays 1; only one done pulse; no second sequence.
- Back-to-back: req=1 with data_in=0 held in the done cycle -> second sequence starts; din=0 in the cycle after done; enable pulse again 2 cycles wide.
- Reset mid-pulse: rst=1 while enable=1 -> next cycle enable=0, busy=0, din=0, done never pulses.
- With LATCH_READBACK_EN, write 1 with q_fb forced 0 -> err=1 with done and sticky. Next write with q_fb=din -> err cleared on accept and stays 0.

Source files
------------

// File: rtl/latch_drive_ctrl.sv
// Sequencer driving din/enable of a level-sensitive latch with setup, pulse and hold phases.
// Optional readback check of the latch output is enabled by defining LATCH_READBACK_EN.
module latch_drive_ctrl #(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic data_in,
  input  logic q_fb,
  output logic din,
  output logic enable,
  output logic busy,
  output logic done,
  output logic err
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
  localparam int CW_RAW  = $clog2(MAX_CYC + 1);
  localparam int CW      = (CW_RAW < 1) ? 1 : CW_RAW;

  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            din_q, din_d;
  logic            enable_q, enable_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            accept;
  logic            last_hold;

  assign accept    = (state_q == IDLE) && req;
  assign last_hold = (state_q == HOLD) && (cnt_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req)                  state_d = SETUP;
      SETUP:   if (cnt_q == SETUP_LAST)  state_d = PULSE;
      PULSE:   if (cnt_q == PULSE_LAST)  state_d = HOLD;
      HOLD:    if (cnt_q == HOLD_LAST)   state_d = IDLE;
      default:                           state_d = IDLE;
    endcase

    if ((state_d != state_q) || (state_q == IDLE)) cnt_d = '0;
    else                                           cnt_d = cnt_q + CW'(1);

    // Outputs are registered, so they follow the state being entered.
    din_d    = accept ? data_in : din_q;
    enable_d = (state_d == PULSE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_q == HOLD) && (state_d == IDLE);
  end

`ifdef LATCH_READBACK_EN
  always_comb begin
    err_d = err_q;
    if (accept)                         err_d = 1'b0;
    else if (last_hold && (q_fb != din_q)) err_d = 1'b1;
  end
`else
  logic unused_readback;
  assign unused_readback = q_fb ^ last_hold;
  assign err_d = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      din_q    <= 1'b0;
      enable_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      din_q    <= din_d;
      enable_q <= enable_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign din    = din_q;
  assign enable = enable_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_latch_drive_ctrl.sv
// Randomized bench for latch_drive_ctrl against a phase-offset reference model.
// Define LATCH_READBACK_EN for both files to cover the readback flag.
module tb_latch_drive_ctrl;

  localparam int S = 1;
  localparam int P = 2;
  localparam int H = 1;
  localparam int T = S + P + H;
  localparam int N_CYC = 3000;

  logic clk = 1'b0;
  logic rst, req, data_in, q_fb;
  logic din, enable, busy, done, err;

  int vecs = 0;
  int miscompares = 0;

  // reference model: position within the sequence rather than a state machine
  bit m_active;
  int m_t;
  bit m_din, m_done, m_err;
  bit prev_en, prev_din;

  latch_drive_ctrl #(.SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .q_fb(q_fb),
    .din(din), .enable(enable), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    vecs++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_active = 0; m_t = 0; m_din = 0; m_done = 0; m_err = 0;
    end else if (!m_active) begin
      m_done = 0;
      if (req) begin
        m_active = 1; m_t = 0; m_din = data_in; m_err = 0;
      end
    end else if (m_t == T - 1) begin
      m_active = 0;
      m_done = 1;
`ifdef LATCH_READBACK_EN
      if (q_fb != m_din) m_err = 1;
`endif
    end else begin
      m_t++;
    end
  endtask

  initial begin
    bit exp_en;
    rst = 1'b1; req = 1'b1; data_in = 1'b1; q_fb = 1'b0;
    prev_en = 0; prev_din = 0;
    for (int cyc = 0; cyc < N_CYC; cyc++) begin
      @(negedge clk);
      if (cyc >= 2) begin
        rst     = ($urandom_range(0, 59) == 0);
        req     = ($urandom_range(0, 9) < 4);
        data_in = $urandom_range(0, 1);
        q_fb    = ($urandom_range(0, 3) == 0) ? ~m_din : m_din;
      end
      @(posedge clk);
      model_step();
      #1;
      exp_en = m_active && (m_t >= S) && (m_t < S + P);
      check("din", din, m_din);
      check("enable", enable, exp_en);
      check("busy", busy, m_active);
      check("done", done, m_done);
      check("err", err, m_err);
      if (prev_en && enable) check("din_stable_in_pulse", din, prev_din);
      if (!prev_en && enable) check("din_stable_at_rise", din, prev_din);
      prev_en = enable;
      prev_din = din;
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
